lpddr2_responder: RTL and testbench
===================================

Name: lpddr2_responder

Overview:
- Memory-side end of the CPU's LPDDR2 request interface.
- Accepts level-held read/write requests (address, write data, rreq, wreq) from the CPU memory stage.
- Converts each request into exactly one Avalon-MM transaction toward the LPDDR2 controller.
- Returns read data and a busy/done handshake to the CPU; sits between the CPU top and the DDR controller IP in the hardware build.

Parameters:
- ADDR_W, 27, word address width on both sides
- DATA_W, 32, data width on both sides
- TIMEOUT_CYCLES, 1023, maximum cycles waiting for avl_readdatavalid before abort (must be ≥1)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- clk  in  1  single clock (CPU and controller side share it)
- rst_n  in  1  asynchronous active-low reset
- lpddr2_address  in  ADDR_W  request word address from CPU
- lpddr2_write_data  in  DATA_W  write data from CPU
- lpddr2_rreq  in  1  read request, held high by CPU until done
- lpddr2_wreq  in  1  write request, held high by CPU until done
- lpddr2_read_data  out  DATA_W  registered read data to CPU
- lpddr2_busy  out  1  high while a transaction is in flight
- lpddr2_done  out  1  one-cycle pulse on completion
- timeout_err  out  1  sticky, set on any read timeout
- local_init_done  in  1  controller calibration complete
- avl_address  out  ADDR_W  Avalon address
- avl_writedata  out  DATA_W  Avalon write data
- avl_byteenable  out  DATA_W/8  always all-ones
- avl_read  out  1  Avalon read command
- avl_write  out  1  Avalon write command
- avl_waitrequest  in  1  Avalon stall
- avl_readdata  in  DATA_W  Avalon read data
- avl_readdatavalid  in  1  Avalon read data strobe

Behaviour:
- Reset (rst_n low, async): state=INIT_WAIT; avl_read=avl_write=0; avl_address=0; avl_writedata=0; lpddr2_read_data=0; busy=1; done=0; timeout_err=0; armed=1; timeout counter=0.
- All outputs are registered.
- INIT_WAIT: busy=1; requests ignored; go to IDLE on the cycle after local_init_done seen high.
- IDLE (busy=0):
  - Request accepted when armed=1 and (rreq|wreq).
  - Address and write data are captured into avl_address/avl_writedata on acceptance.
  - wreq → WRITE; else rreq → READ_CMD.
  - rreq&wreq both high: write takes priority, read is dropped (no separate read issued).
  - On acceptance busy=1 the next cycle and armed←0.
- WRITE: avl_write=1 held until the cycle avl_waitrequest=0; then deassert, go DONE.
- READ_CMD: avl_read=1 held until avl_waitrequest=0; then deassert, clear counter, go READ_WAIT.
- READ_WAIT:
  - On avl_readdatavalid: capture avl_readdata into lpddr2_read_data, go DONE.
  - Otherwise counter increments; counter==TIMEOUT_CYCLES-1 without valid → read_data←ERR_DATA, timeout_err←1, go DONE.
  - readdatavalid on the same cycle as the terminal count: data wins, no error.
  - readdatavalid outside READ_WAIT is ignored.
- DONE: done=1 for exactly one cycle, busy=0 from the next cycle, go IDLE.
- Re-arm: armed←1 in any cycle where rreq=0 and wreq=0. This stops a still-held request from being re-issued.
  - Minimum spacing between back-to-back requests: one idle-low cycle.
- lpddr2_read_data holds its value until the next read completes; writes do not change it.
- local_init_done falling outside INIT_WAIT is ignored.
- Reset mid-transaction: avl_read/avl_write drop asynchronously. A late readdatavalid after reset is ignored, since state is INIT_WAIT.
- Latency with waitrequest=0 and readdatavalid at the first READ_WAIT cycle:
  - write: accept → done pulse 2 cycles later.
  - read: accept → done pulse 3 cycles later.

Test Plan:
- Init gating: hold local_init_done=0, assert rreq → no avl_read, busy=1. Raise init_done → request serviced afterward.
- Write: wreq with addr=27'h123, data=32'hCAFE0001, waitrequest high 3 cycles → avl_write held exactly 4 cycles with those values, single done pulse, read_data unchanged.
- Read: rreq with addr=27'h40, readdatavalid with 32'h12345678 after 5 cycles → read_data=32'h12345678 at done, timeout_err=0.
- Held request: keep rreq high 20 cycles after done → exactly one avl_read issued. Drop rreq 1 cycle and raise again → second read issued.
- Timeout: TIMEOUT_CYCLES=8, never assert readdatavalid → done after 8 wait cycles, read_data=32'hDEAD_BEEF, timeout_err sticky until rst_n.
- Priority/reset: rreq&wreq together → only avl_write. Assert rst_n=0 mid-READ_WAIT → avl_read=0, busy=1, read_data=0 immediately.

Source files
------------

// File: rtl/lpddr2_responder.sv
// lpddr2_responder: memory-side end of the CPU LPDDR2 request interface.
// Turns each level-held CPU read/write request into exactly one Avalon-MM
// transaction toward the DDR controller, and returns read data plus a
// busy/done handshake. A read that never sees readdatavalid is aborted
// after TIMEOUT_CYCLES wait cycles and returns ERR_DATA.
module lpddr2_responder #(
  parameter int                ADDR_W         = 27,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1023,
  parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  // CPU side
  input  logic [ADDR_W-1:0]   lpddr2_address,
  input  logic [DATA_W-1:0]   lpddr2_write_data,
  input  logic                lpddr2_rreq,
  input  logic                lpddr2_wreq,
  output logic [DATA_W-1:0]   lpddr2_read_data,
  output logic                lpddr2_busy,
  output logic                lpddr2_done,
  output logic                timeout_err,
  // controller side
  input  logic                local_init_done,
  output logic [ADDR_W-1:0]   avl_address,
  output logic [DATA_W-1:0]   avl_writedata,
  output logic [DATA_W/8-1:0] avl_byteenable,
  output logic                avl_read,
  output logic                avl_write,
  input  logic                avl_waitrequest,
  input  logic [DATA_W-1:0]   avl_readdata,
  input  logic                avl_readdatavalid
);

  // Wait counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT_WAIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ_CMD,
    ST_READ_WAIT,
    ST_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic                armed_reg, armed_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                avl_read_reg, avl_read_next;
  logic                avl_write_reg, avl_write_next;
  logic [ADDR_W-1:0]   avl_address_reg, avl_address_next;
  logic [DATA_W-1:0]   avl_writedata_reg, avl_writedata_next;
  logic [DATA_W-1:0]   read_data_reg, read_data_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                timeout_err_reg, timeout_err_next;

  // Full-word accesses only: every byte lane is always enabled.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_byteenable
      assign avl_byteenable[gi] = 1'b1;
    end
  endgenerate

  assign avl_read         = avl_read_reg;
  assign avl_write        = avl_write_reg;
  assign avl_address      = avl_address_reg;
  assign avl_writedata    = avl_writedata_reg;
  assign lpddr2_read_data = read_data_reg;
  assign lpddr2_busy      = busy_reg;
  assign lpddr2_done      = done_reg;
  assign timeout_err      = timeout_err_reg;

  // State and registered outputs; reset drops the Avalon commands immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_INIT_WAIT;
      armed_reg         <= 1'b1;
      cnt_reg           <= '0;
      avl_read_reg      <= 1'b0;
      avl_write_reg     <= 1'b0;
      avl_address_reg   <= '0;
      avl_writedata_reg <= '0;
      read_data_reg     <= '0;
      busy_reg          <= 1'b1;
      done_reg          <= 1'b0;
      timeout_err_reg   <= 1'b0;
    end else begin
      state_reg         <= state_next;
      armed_reg         <= armed_next;
      cnt_reg           <= cnt_next;
      avl_read_reg      <= avl_read_next;
      avl_write_reg     <= avl_write_next;
      avl_address_reg   <= avl_address_next;
      avl_writedata_reg <= avl_writedata_next;
      read_data_reg     <= read_data_next;
      busy_reg          <= busy_next;
      done_reg          <= done_next;
      timeout_err_reg   <= timeout_err_next;
    end
  end

  // Next-state and next-output logic for the request sequencer.
  always_comb begin
    state_next         = state_reg;
    armed_next         = armed_reg;
    cnt_next           = cnt_reg;
    avl_read_next      = avl_read_reg;
    avl_write_next     = avl_write_reg;
    avl_address_next   = avl_address_reg;
    avl_writedata_next = avl_writedata_reg;
    read_data_next     = read_data_reg;
    timeout_err_next   = timeout_err_reg;

    // A request line seen low re-arms acceptance, so a request still held
    // after its done pulse is not issued a second time.
    if (!lpddr2_rreq && !lpddr2_wreq) begin
      armed_next = 1'b1;
    end

    case (state_reg)
      ST_INIT_WAIT: begin
        if (local_init_done) begin
          state_next = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (armed_reg && (lpddr2_rreq || lpddr2_wreq)) begin
          avl_address_next   = lpddr2_address;
          avl_writedata_next = lpddr2_write_data;
          armed_next         = 1'b0;
          // Write wins when both are raised; the read is simply dropped.
          if (lpddr2_wreq) begin
            avl_write_next = 1'b1;
            state_next     = ST_WRITE;
          end else begin
            avl_read_next  = 1'b1;
            state_next     = ST_READ_CMD;
          end
        end
      end

      ST_WRITE: begin
        if (!avl_waitrequest) begin
          avl_write_next = 1'b0;
          state_next     = ST_DONE;
        end
      end

      ST_READ_CMD: begin
        if (!avl_waitrequest) begin
          avl_read_next = 1'b0;
          cnt_next      = '0;
          state_next    = ST_READ_WAIT;
        end
      end

      ST_READ_WAIT: begin
        // Data arriving on the terminal-count cycle still counts as success.
        if (avl_readdatavalid) begin
          read_data_next = avl_readdata;
          state_next     = ST_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          read_data_next   = ERR_DATA;
          timeout_err_next = 1'b1;
          state_next       = ST_DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_INIT_WAIT;
      end
    endcase

    // Busy covers everything except IDLE; done marks the single DONE cycle.
    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_DONE);
  end

endmodule

// File: tb/tb_lpddr2_responder.sv
// tb_lpddr2_responder: directed plus randomized transactions against a
// bench-side Avalon slave with a word memory. Expected read data, error
// flag, command counts and completion latency come from the bench model.
module tb_lpddr2_responder;

  localparam int          ADDR_W = 27;
  localparam int          DATA_W = 32;
  localparam int          TMO    = 8;
  localparam logic [31:0] ERR    = 32'hDEAD_BEEF;

  logic                clk;
  logic                rst_n;
  logic [ADDR_W-1:0]   lpddr2_address;
  logic [DATA_W-1:0]   lpddr2_write_data;
  logic                lpddr2_rreq;
  logic                lpddr2_wreq;
  logic [DATA_W-1:0]   lpddr2_read_data;
  logic                lpddr2_busy;
  logic                lpddr2_done;
  logic                timeout_err;
  logic                local_init_done;
  logic [ADDR_W-1:0]   avl_address;
  logic [DATA_W-1:0]   avl_writedata;
  logic [DATA_W/8-1:0] avl_byteenable;
  logic                avl_read;
  logic                avl_write;
  logic                avl_waitrequest;
  logic [DATA_W-1:0]   avl_readdata;
  logic                avl_readdatavalid;

  int checks = 0;
  int errors = 0;

  // Bench model: slave memory contents and the CPU-visible expectations.
  logic [31:0] mem [int];
  logic [31:0] exp_rd;
  logic        exp_terr;

  lpddr2_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lpddr2_address(lpddr2_address), .lpddr2_write_data(lpddr2_write_data),
    .lpddr2_rreq(lpddr2_rreq), .lpddr2_wreq(lpddr2_wreq),
    .lpddr2_read_data(lpddr2_read_data), .lpddr2_busy(lpddr2_busy),
    .lpddr2_done(lpddr2_done), .timeout_err(timeout_err),
    .local_init_done(local_init_done),
    .avl_address(avl_address), .avl_writedata(avl_writedata),
    .avl_byteenable(avl_byteenable), .avl_read(avl_read), .avl_write(avl_write),
    .avl_waitrequest(avl_waitrequest), .avl_readdata(avl_readdata),
    .avl_readdatavalid(avl_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU request, with the bench acting as Avalon slave. wait_n cycles of
  // waitrequest, read data on READ_WAIT cycle vdelay (0 = never), request held
  // for 'hold' extra cycles after done.
  task automatic txn(input string tag, input bit wr, input bit both,
                     input logic [26:0] a, input logic [31:0] d,
                     input int wait_n, input int vdelay, input int hold);
    bit          is_wr, valid_ok, addr_ok, in_wait, go_wait;
    int          n, cmd_n, other_n, done_n, done_at, rw_idx, extra, exp_done;
    logic [31:0] ret;
    is_wr    = wr | both;
    valid_ok = (vdelay >= 1) && (vdelay <= TMO);
    addr_ok  = 1'b1;
    in_wait  = 1'b0;
    go_wait  = 1'b0;
    n = 0; cmd_n = 0; other_n = 0; done_n = 0; done_at = 0; rw_idx = 0; extra = 0;
    ret = '0;
    if (is_wr) begin
      mem[int'(a)] = d;
      exp_done     = 2 + wait_n;
    end else begin
      if (mem.exists(int'(a))) ret = mem[int'(a)];
      else begin
        ret          = $urandom;
        mem[int'(a)] = ret;
      end
      if (valid_ok) begin
        exp_rd   = ret;
        exp_done = 2 + wait_n + vdelay;
      end else begin
        exp_rd   = ERR;
        exp_terr = 1'b1;
        exp_done = 2 + wait_n + TMO;
      end
    end

    lpddr2_address    = a;
    lpddr2_write_data = d;
    lpddr2_wreq       = is_wr;
    lpddr2_rreq       = both | !wr;
    avl_waitrequest   = (wait_n > 0);
    avl_readdatavalid = 1'b0;

    while (done_n == 0 && n < 64) begin
      @(negedge clk);
      n++;
      avl_readdatavalid = 1'b0;
      avl_readdata      = $urandom;
      if (lpddr2_done) begin
        done_n  = 1;
        done_at = n;
        chk({tag, "_rdata"}, lpddr2_read_data, exp_rd);
        chk({tag, "_terr"}, timeout_err, exp_terr);
      end else begin
        if (go_wait) begin
          in_wait = 1'b1;
          go_wait = 1'b0;
        end
        if (in_wait) begin
          rw_idx++;
          if (rw_idx == vdelay) begin
            avl_readdatavalid = 1'b1;
            avl_readdata      = ret;
          end
        end
        if (is_wr ? avl_write : avl_read) begin
          cmd_n++;
          if (avl_address !== a || (is_wr && avl_writedata !== d)) addr_ok = 1'b0;
          avl_waitrequest = (cmd_n <= wait_n);
          if (!is_wr && cmd_n > wait_n) go_wait = 1'b1;
        end
        if (is_wr ? avl_read : avl_write) other_n++;
      end
    end
    avl_readdatavalid = 1'b0;

    repeat (hold) begin
      @(negedge clk);
      if (avl_read || avl_write || lpddr2_done) extra++;
    end
    if (hold > 0) chk({tag, "_held_reissue"}, extra, 0);
    lpddr2_rreq = 1'b0;
    lpddr2_wreq = 1'b0;
    @(negedge clk);

    chk({tag, "_done_seen"}, done_n, 1);
    chk({tag, "_latency"}, done_at, exp_done);
    chk({tag, "_cmd_cycles"}, cmd_n, wait_n + 1);
    chk({tag, "_other_cmd"}, other_n, 0);
    chk({tag, "_addr_data"}, addr_ok, 1);
    chk({tag, "_busy_after"}, lpddr2_busy, 0);
    chk({tag, "_done_after"}, lpddr2_done, 0);
    $display("txn %s: %s addr=%0h wdata=%0h wait=%0d vdelay=%0d done_at=%0d rdata=%0h terr=%0b",
             tag, is_wr ? "WR" : "RD", a, d, wait_n, vdelay, done_at, lpddr2_read_data, timeout_err);
  endtask

  // Release reset with init_done already high; valid pulses while the
  // responder is not waiting for read data must be ignored.
  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n             = 1'b1;
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'hBAD0_0001;
    @(negedge clk);
    chk({tag, "_idle_busy"}, lpddr2_busy, 0);
    chk({tag, "_late_valid"}, lpddr2_read_data, exp_rd);
    avl_readdata = 32'hBAD0_0002;
    @(negedge clk);
    avl_readdatavalid = 1'b0;
    chk({tag, "_idle_valid"}, lpddr2_read_data, exp_rd);
    $display("txn %s: reset released, rdata=%0h busy=%0b", tag, lpddr2_read_data, lpddr2_busy);
  endtask

  task automatic random_txns(input string tag, input int count);
    bit          wr, both;
    logic [26:0] a;
    for (int i = 0; i < count; i++) begin
      wr   = $urandom_range(0, 1) == 1;
      both = $urandom_range(0, 7) == 0;
      a    = 27'($urandom_range(0, 7) * 16 + 27'h400);
      txn($sformatf("%s%0d", tag, i), wr, both, a, $urandom,
          $urandom_range(0, 3), $urandom_range(0, TMO), 0);
    end
  endtask

  initial begin
    bit gate_ok;
    rst_n             = 1'b0;
    local_init_done   = 1'b0;
    lpddr2_address    = '0;
    lpddr2_write_data = '0;
    lpddr2_rreq       = 1'b0;
    lpddr2_wreq       = 1'b0;
    avl_waitrequest   = 1'b0;
    avl_readdata      = '0;
    avl_readdatavalid = 1'b0;
    exp_rd            = '0;
    exp_terr          = 1'b0;
    mem[int'(27'h40)] = 32'h1234_5678;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_busy", lpddr2_busy, 1);
    chk("rst_done", lpddr2_done, 0);
    chk("rst_avl_read", avl_read, 0);
    chk("rst_avl_write", avl_write, 0);
    chk("rst_avl_addr", avl_address, 0);
    chk("rst_avl_wdata", avl_writedata, 0);
    chk("rst_rdata", lpddr2_read_data, 0);
    chk("rst_terr", timeout_err, 0);
    chk("byteenable", avl_byteenable, 4'hF);
    $display("txn reset: busy=%0b rdata=%0h", lpddr2_busy, lpddr2_read_data);

    // Requests are ignored until calibration completes.
    rst_n          = 1'b1;
    lpddr2_address = 27'h40;
    lpddr2_rreq    = 1'b1;
    gate_ok        = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (avl_read !== 1'b0 || lpddr2_busy !== 1'b1) gate_ok = 1'b0;
    end
    chk("init_gate", gate_ok, 1);
    local_init_done = 1'b1;
    @(negedge clk);
    chk("init_idle_busy", lpddr2_busy, 0);
    $display("txn init: gated=%0b busy=%0b", gate_ok, lpddr2_busy);

    // Directed transactions.
    txn("read40",     0, 0, 27'h40,  32'h0,         0, 5,   0);
    txn("write123",   1, 0, 27'h123, 32'hCAFE_0001, 3, 0,   0);
    txn("read123",    0, 0, 27'h123, 32'h0,         1, 1,   0);
    txn("write_lat",  1, 0, 27'h124, 32'h0000_00A5, 0, 0,   0);
    txn("read_lat",   0, 0, 27'h124, 32'h0,         0, 1,   0);
    txn("held",       0, 0, 27'h77,  32'h0,         0, 2,   20);
    txn("rearm",      0, 0, 27'h77,  32'h0,         0, 3,   0);
    txn("timeout",    0, 0, 27'h99,  32'h0,         0, 0,   0);
    txn("term_count", 0, 0, 27'h98,  32'h0,         2, TMO, 0);
    txn("both",       0, 1, 27'h200, 32'h5A5A_A5A5, 1, 0,   0);
    txn("read_both",  0, 0, 27'h200, 32'h0,         0, 4,   0);

    // Randomized transactions.
    random_txns("rnd_a", 40);

    // Reset while the read command is stalled: the command drops at once.
    lpddr2_address  = 27'h300;
    lpddr2_rreq     = 1'b1;
    avl_waitrequest = 1'b1;
    @(negedge clk);
    chk("rstA_pre_read", avl_read, 1);
    rst_n = 1'b0;
    #1;
    chk("rstA_avl_read", avl_read, 0);
    chk("rstA_busy", lpddr2_busy, 1);
    chk("rstA_terr", timeout_err, 0);
    lpddr2_rreq     = 1'b0;
    avl_waitrequest = 1'b0;
    exp_rd          = '0;
    exp_terr        = 1'b0;
    $display("txn rstA: avl_read=%0b busy=%0b", avl_read, lpddr2_busy);
    release_reset("rstA");

    // Reset while waiting for read data: read data clears immediately.
    mem[int'(27'h310)] = 32'h0BAD_F00D;
    txn("pre_rstB", 0, 0, 27'h310, 32'h0, 0, 2, 0);
    lpddr2_address = 27'h311;
    lpddr2_rreq    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstB_pre_rdata", lpddr2_read_data, 32'h0BAD_F00D);
    rst_n = 1'b0;
    #1;
    chk("rstB_avl_read", avl_read, 0);
    chk("rstB_busy", lpddr2_busy, 1);
    chk("rstB_rdata", lpddr2_read_data, 0);
    lpddr2_rreq = 1'b0;
    exp_rd      = '0;
    exp_terr    = 1'b0;
    $display("txn rstB: rdata=%0h busy=%0b", lpddr2_read_data, lpddr2_busy);
    release_reset("rstB");

    // Losing init_done after calibration does not stall the responder.
    local_init_done = 1'b0;
    random_txns("rnd_b", 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
